// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// The MCTRL_HALT_EN build adds the HALT state usage; the encodings here are build-independent.
package mctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int unsigned OP_ALUI0 = 0;
  localparam int unsigned OP_ALUI1 = 1;
  localparam int unsigned OP_ALUI2 = 2;
  localparam int unsigned OP_BR1   = 3;
  localparam int unsigned OP_BR2   = 4;
  localparam int unsigned OP_LOAD  = 5;
  localparam int unsigned OP_STORE = 6;
  localparam int unsigned OP_ALUR0 = 7;
  localparam int unsigned OP_ALUR1 = 8;
  localparam int unsigned OP_CALL  = 9;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_I0   = 3'b001;
  localparam logic [2:0] ALU_I1   = 3'b010;
  localparam logic [2:0] ALU_I2   = 3'b011;
  localparam logic [2:0] ALU_LD   = 3'b100;
  localparam logic [2:0] ALU_ST   = 3'b101;
  localparam logic [2:0] ALU_R0   = 3'b110;
  localparam logic [2:0] ALU_R1   = 3'b111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_C1   = 2'b01;
  localparam logic [1:0] BR_C2   = 2'b10;
  localparam logic [1:0] BR_CALL = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_RA  = 2'b10;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_P0   = 2'b01;
  localparam logic [1:0] RW_P1   = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_write;
    logic [1:0] branch;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  // Conditional branches return to FETCH after EXEC; a call still writes back.
  function automatic logic is_cond_branch(input logic [1:0] br);
    return (br == BR_C1) || (br == BR_C2);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake and control-output bundle between the control unit and the datapath.
// The halted signal exists only when MCTRL_HALT_EN is defined.
interface multicycle_control_if #(
  parameter int unsigned OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                ir_write;
  logic                pc_write;
  logic                alu_src;
  logic [2:0]          alu_op;
  logic [1:0]          branch;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          mem_to_reg;
  logic [1:0]          reg_write;
  logic [2:0]          state;
  logic                illegal_op;
  logic                bus_err;
`ifdef MCTRL_HALT_EN
  logic                halted;
`endif

  modport master (
`ifdef MCTRL_HALT_EN
    output halted,
`endif
    input  opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, alu_src, alu_op, branch,
           mem_read, mem_write, mem_to_reg, reg_write, state, illegal_op, bus_err
  );

  modport slave (
`ifdef MCTRL_HALT_EN
    input  halted,
`endif
    output opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, alu_src, alu_op, branch,
           mem_read, mem_write, mem_to_reg, reg_write, state, illegal_op, bus_err
  );
endinterface

// File: rtl/mctrl_decode.sv
// Combinational opcode decoder: opcode -> control word, illegal and halt flags.
// With MCTRL_HALT_EN the all-ones opcode decodes to halt instead of illegal.
module mctrl_decode
  import mctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o,
  output logic                halt_o
);

  logic [31:0] op;

  always_comb begin
    op        = 32'(opcode_i);
    ctrl_o    = '0;
    illegal_o = 1'b0;
    halt_o    = 1'b0;
    case (op)
      OP_ALUI0: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_I0; ctrl_o.reg_write = RW_P1;
      end
      OP_ALUI1: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_I1; ctrl_o.reg_write = RW_P1;
      end
      OP_ALUI2: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_I2; ctrl_o.reg_write = RW_P1;
      end
      OP_BR1: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_PASS; ctrl_o.branch = BR_C1;
      end
      OP_BR2: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_PASS; ctrl_o.branch = BR_C2;
      end
      OP_LOAD: begin
        ctrl_o.alu_op = ALU_LD; ctrl_o.mem_to_reg = WB_MEM; ctrl_o.reg_write = RW_P1;
        ctrl_o.mem_read = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alu_op = ALU_ST; ctrl_o.mem_write = 1'b1;
      end
      OP_ALUR0: begin
        ctrl_o.alu_op = ALU_R0; ctrl_o.reg_write = RW_P1;
      end
      OP_ALUR1: begin
        ctrl_o.alu_op = ALU_R1; ctrl_o.reg_write = RW_P1;
      end
      OP_CALL: begin
        ctrl_o.alu_src = 1'b1; ctrl_o.alu_op = ALU_PASS; ctrl_o.mem_to_reg = WB_RA;
        ctrl_o.reg_write = RW_P0; ctrl_o.branch = BR_CALL;
      end
      default: illegal_o = 1'b1;
    endcase
`ifdef MCTRL_HALT_EN
    if (opcode_i == '1) begin
      ctrl_o    = '0;
      illegal_o = 1'b0;
      halt_o    = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, registered control
// word, per-access wait-state watchdog and phase gating. Optional macro: MCTRL_HALT_EN.
module multicycle_control
  import mctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic        WD_EN = (WAIT_MAX != 0);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_halt;
  logic  waiting;
  logic  expired;

  mctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode_i  (bus.opcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .halt_o    (dec_halt)
  );

  assign waiting = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                   ((state_q == ST_MEM)   && !bus.dmem_ready);
  assign expired = WD_EN && waiting && (wcnt_q == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ctrl_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) state_d = ST_DECODE;
        else if (expired)   state_d = ST_FETCH;
      end
      ST_DECODE: begin
        ctrl_d = dec_illegal ? '0 : dec_ctrl;
        if (dec_illegal)   state_d = ST_FETCH;
        else if (dec_halt) state_d = ST_HALT;
        else               state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctrl_q.mem_read || ctrl_q.mem_write) state_d = ST_MEM;
        else if (is_cond_branch(ctrl_q.branch))  state_d = ST_FETCH;
        else                                     state_d = ST_WB;
      end
      ST_MEM: begin
        if (bus.dmem_ready) state_d = ctrl_q.mem_read ? ST_WB : ST_FETCH;
        else if (expired)   state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // A timeout in FETCH keeps the state unchanged, so it must clear the count explicitly.
  always_comb begin
    wcnt_d = wcnt_q;
    if ((state_d != state_q) || expired) wcnt_d = '0;
    else if (waiting && WD_EN)           wcnt_d = wcnt_q + 1'b1;
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = '0;
    bus.branch     = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = '0;
    bus.reg_write  = '0;
    bus.illegal_op = 1'b0;
    bus.bus_err    = expired;
    bus.state      = state_q;
    case (state_q)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
        bus.pc_write = bus.imem_ready;
      end
      ST_DECODE: bus.illegal_op = dec_illegal;
      ST_EXEC: begin
        bus.alu_src = ctrl_q.alu_src;
        bus.alu_op  = ctrl_q.alu_op;
        bus.branch  = ctrl_q.branch;
      end
      ST_MEM: begin
        bus.alu_src   = ctrl_q.alu_src;
        bus.alu_op    = ctrl_q.alu_op;
        bus.mem_read  = ctrl_q.mem_read;
        bus.mem_write = ctrl_q.mem_write;
      end
      ST_WB: begin
        bus.alu_src    = ctrl_q.alu_src;
        bus.alu_op     = ctrl_q.alu_op;
        bus.mem_to_reg = ctrl_q.mem_to_reg;
        bus.reg_write  = ctrl_q.reg_write;
      end
      default: ;
    endcase
  end

`ifdef MCTRL_HALT_EN
  assign bus.halted = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-cycle stimulus and expected outputs are queued from a
// reference opcode table, then replayed and compared cycle by cycle.
module tb_multicycle_control;

  localparam int unsigned OW = 6;
  localparam int unsigned WM = 3;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_write, pc_write, alu_src;
    logic [2:0] alu_op;
    logic [1:0] branch;
    logic       mem_read, mem_write;
    logic [1:0] m2r, rw;
    logic       ill, berr, halted;
  } obs_t;

  typedef struct {
    logic          imem_ready;
    logic          dmem_ready;
    logic [OW-1:0] opcode;
  } stim_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  typedef struct packed {
    logic       legal, src;
    logic [2:0] aop;
    logic [1:0] m2r, rw, br;
  } ref_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(OW)) bus();

  multicycle_control #(.OPCODE_W(OW), .WAIT_MAX(WM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st       = bus.state;
    o.imem_req = bus.imem_req;
    o.ir_write = bus.ir_write;
    o.pc_write = bus.pc_write;
    o.alu_src  = bus.alu_src;
    o.alu_op   = bus.alu_op;
    o.branch   = bus.branch;
    o.mem_read = bus.mem_read;
    o.mem_write= bus.mem_write;
    o.m2r      = bus.mem_to_reg;
    o.rw       = bus.reg_write;
    o.ill      = bus.illegal_op;
    o.berr     = bus.bus_err;
`ifdef MCTRL_HALT_EN
    o.halted   = bus.halted;
`else
    o.halted   = 1'b0;
`endif
    return o;
  endfunction

  function automatic ref_t ref_of(input int unsigned op);
    ref_t r = '0;
    r.legal = 1'b1;
    case (op)
      0: begin r.src = 1; r.aop = 3'b001; r.rw = 2'b10; end
      1: begin r.src = 1; r.aop = 3'b010; r.rw = 2'b10; end
      2: begin r.src = 1; r.aop = 3'b011; r.rw = 2'b10; end
      3: begin r.src = 1; r.br = 2'b01; end
      4: begin r.src = 1; r.br = 2'b10; end
      5: begin r.aop = 3'b100; r.m2r = 2'b01; r.rw = 2'b10; end
      6: begin r.aop = 3'b101; end
      7: begin r.aop = 3'b110; r.rw = 2'b10; end
      8: begin r.aop = 3'b111; r.rw = 2'b10; end
      9: begin r.src = 1; r.m2r = 2'b10; r.rw = 2'b01; r.br = 2'b11; end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o = '0;
    o.imem_req = 1'b1;
    return o;
  endfunction

  task automatic push(input logic ir, input logic dr, input logic [OW-1:0] op,
                      input obs_t v, input string tag);
    stim_t s;
    exp_t  e;
    s.imem_ready = ir;
    s.dmem_ready = dr;
    s.opcode     = op;
    e.v   = v;
    e.tag = tag;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Inputs outside their own phase are randomised to show they are ignored.
  task automatic gen_fetch(input int unsigned iw, input string tag);
    obs_t e;
    for (int unsigned k = 0; k <= iw; k++) begin
      e = '0;
      e.imem_req = 1'b1;
      e.ir_write = (k == iw);
      e.pc_write = (k == iw);
      push((k == iw), 1'($urandom), OW'($urandom), e, $sformatf("%s_fetch%0d", tag, k));
    end
  endtask

  task automatic gen_fetch_timeout(input string tag);
    obs_t e;
    for (int unsigned k = 0; k <= WM; k++) begin
      e = '0;
      e.imem_req = 1'b1;
      e.berr     = (k == WM);
      push(1'b0, 1'($urandom), OW'($urandom), e, $sformatf("%s_fto%0d", tag, k));
    end
  endtask

  // dw > WM selects a data-memory timeout.
  task automatic gen_instr(input int unsigned op, input int unsigned iw,
                           input int unsigned dw, input string tag);
    ref_t r = ref_of(op);
    obs_t e;
    logic is_mem;
    gen_fetch(iw, tag);
    e = '0;
    e.st  = 3'd1;
    e.ill = !r.legal;
    push(1'($urandom), 1'($urandom), OW'(op), e, {tag, "_dec"});
    if (!r.legal) return;
    e = '0;
    e.st = 3'd2; e.alu_src = r.src; e.alu_op = r.aop; e.branch = r.br;
    push(1'($urandom), 1'($urandom), OW'($urandom), e, {tag, "_exec"});
    is_mem = (op == 5) || (op == 6);
    if (is_mem) begin
      for (int unsigned k = 0; k <= ((dw > WM) ? WM : dw); k++) begin
        e = '0;
        e.st = 3'd3; e.alu_src = r.src; e.alu_op = r.aop;
        e.mem_read  = (op == 5);
        e.mem_write = (op == 6);
        e.berr      = (dw > WM) && (k == WM);
        push(1'($urandom), (dw <= WM) && (k == dw), OW'($urandom), e,
             $sformatf("%s_mem%0d", tag, k));
      end
      if (dw > WM) return;
    end
    if (op == 3 || op == 4 || op == 6) return;
    e = '0;
    e.st = 3'd4; e.alu_src = r.src; e.alu_op = r.aop; e.m2r = r.m2r; e.rw = r.rw;
    push(1'($urandom), 1'($urandom), OW'($urandom), e, {tag, "_wb"});
  endtask

  task automatic run_queue();
    stim_t s;
    exp_t  e;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      bus.imem_ready = s.imem_ready;
      bus.dmem_ready = s.dmem_ready;
      bus.opcode     = s.opcode;
      #1;
      e = exp_q.pop_front();
      check_eq(e.tag, 32'(sample()), 32'(e.v));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    obs_t e;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.opcode     = '0;
    #13;
    check_eq("reset_state", 32'(sample()), 32'(reset_obs()));
    release_reset();

    gen_instr(5, 0, 2, "load_dw2");
    gen_instr(3, 0, 0, "br1");
    gen_instr(9, 0, 0, "call");
    gen_instr(12, 0, 0, "ill12");
    gen_instr(0, 1, 0, "alui0");
    gen_instr(1, 0, 0, "alui1");
    gen_instr(2, 2, 0, "alui2");
    gen_instr(7, 0, 0, "alur0");
    gen_instr(8, 0, 0, "alur1");
    gen_instr(6, 0, 0, "store");
    gen_instr(4, 0, 0, "br2");
    gen_instr(15, 0, 0, "ill15");
`ifndef MCTRL_HALT_EN
    gen_instr(63, 0, 0, "ill63");
`endif
    gen_fetch_timeout("wd_fetch");
    gen_instr(0, WM, 0, "ready_at_max");
    gen_instr(5, 0, WM, "load_dw_max");
    gen_instr(5, 0, WM + 1, "load_timeout");
    gen_instr(6, 1, WM + 1, "store_timeout");
    gen_instr(9, 0, 0, "call_after_to");
    run_queue();

    gen_fetch(0, "rst_store");
    e = '0; e.st = 3'd1;
    push(1'b0, 1'b0, OW'(6), e, "rst_store_dec");
    e = '0; e.st = 3'd2; e.alu_op = 3'b101;
    push(1'b0, 1'b0, OW'(0), e, "rst_store_exec");
    e = '0; e.st = 3'd3; e.alu_op = 3'b101; e.mem_write = 1'b1;
    push(1'b0, 1'b0, OW'(0), e, "rst_store_mem");
    run_queue();
    #1 rst_n = 1'b0;
    #1 check_eq("async_reset_mid_mem", 32'(sample()), 32'(reset_obs()));
    bus.imem_ready = 1'b0;
    release_reset();
    gen_instr(1, 0, 0, "post_reset");
    run_queue();

`ifdef MCTRL_HALT_EN
    gen_fetch(0, "halt");
    e = '0; e.st = 3'd1;
    push(1'b1, 1'b0, OW'(63), e, "halt_dec");
    for (int unsigned k = 0; k < 5; k++) begin
      e = '0; e.st = 3'd5; e.halted = 1'b1;
      push(1'b1, 1'b1, OW'($urandom), e, $sformatf("halt_hold%0d", k));
    end
    run_queue();
    #1 rst_n = 1'b0;
    #1 check_eq("halt_reset", 32'(sample()), 32'(reset_obs()));
    bus.imem_ready = 1'b0;
    release_reset();
    gen_instr(7, 0, 0, "after_halt");
    run_queue();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RISC core; the sequential successor to the single-cycle opcode decoder. Fetched opcodes are decoded into a registered control word and sequenced through FETCH/DECODE/EXEC/MEM/WB, with each control signal asserted only in its own phase. Instruction and data memory accesses wait on ready handshakes, and a wait-state watchdog bounds each access. Sits between the instruction register and the datapath muxes, ALU, register file and memories.

## Interface
- OPCODE_W, 6, opcode width; must be ≥ 4; opcode compared zero-extended
- WAIT_MAX, 15, max wait cycles per memory access; 0 disables the watchdog
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  opcode field of the instruction register; sampled in DECODE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  PC update (sequential)
- alu_src  out  1  ALU B-operand select (1 = immediate)
- alu_op  out  3  ALU operation
- branch  out  2  branch/jump type (01, 10 conditional; 11 call)
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- mem_to_reg  out  2  write-back select (00 ALU, 01 memory, 10 return address)
- reg_write  out  2  register-file write enable/port select
- state  out  3  FSM state
- illegal_op  out  1  one-cycle pulse for an undefined opcode
- bus_err  out  1  one-cycle pulse when the watchdog expires
- halted  out  1  core halted (only with the macro)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Opcode map (ctrl = alu_src/alu_op/mem_to_reg/reg_write/branch):
  - 0,1,2: 1/001,010,011/00/10/00 (ALU-imm)
  - 3: 1/000/00/00/01
  - 4: 1/000/00/00/10
  - 5: 0/100/01/10/00 (load)
  - 6: 0/101/00/00/00 (store)
  - 7,8: 0/110,111/00/10/00 (ALU-reg)
  - 9: 1/000/10/01/11 (call)
  - All others are illegal.
- Paths:
  - ALU ops: FETCH→DECODE→EXEC→WB.
  - Branch (3, 4): FETCH→DECODE→EXEC→FETCH.
  - Load: FETCH→DECODE→EXEC→MEM→WB.
  - Store: FETCH→DECODE→EXEC→MEM→FETCH.
  - Call: FETCH→DECODE→EXEC→WB.
- Illegal opcode: DECODE→FETCH; illegal_op pulses in DECODE; no writes.
- DECODE registers the control word; alu_src/alu_op are held from EXEC through WB.
- Phase gating (0 in all other states):
  - branch: EXEC only.
  - mem_read/mem_write: MEM only.
  - reg_write/mem_to_reg: WB only.
- FETCH:
  - imem_req=1.
  - ir_write=pc_write=imem_ready (combinational).
  - Advances to DECODE on imem_ready.
- MEM: holds mem_read/mem_write until dmem_ready; leaves MEM in the cycle dmem_ready=1.
- Watchdog:
  - Counter of width $clog2(WAIT_MAX+1); increments each FETCH/MEM cycle without ready; clears on every state change.
  - When count==WAIT_MAX and ready=0: bus_err pulses, state→FETCH, no ir/pc/reg write.
  - If ready and count==WAIT_MAX occur together, ready wins and there is no bus_err.

## Timing
- Reset (async assert, sync deassert):
  - state=FETCH, control word=0, counter=0.
  - All outputs 0 except imem_req=1.
- Latency with zero wait states:
  - ALU and call: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each cycle of wait state extends FETCH/MEM by one cycle.
- Reset mid-access: immediate return to FETCH; no write strobe survives reset.
- Opcode changes outside DECODE are ignored.

## Configuration
- MCTRL_HALT_EN defined:
  - All-ones opcode ({OPCODE_W{1'b1}}) goes DECODE→HALT.
  - HALT: every output is 0 including imem_req; halted=1; exit only via rst_n.
- Undefined: the all-ones opcode is illegal; the halted port is absent.

## Structure
- Package mctrl_pkg holds:
  - state enum.
  - opcode constants.
  - alu_op, branch, mem_to_reg and reg_write encodings.
  - packed ctrl_t struct.
- Sub-module mctrl_decode: combinational opcode→ctrl_t plus illegal flag.
- Top level: FSM, control-word register, watchdog counter, phase gating.

## Test plan
- Opcode 5, imem_ready=1, dmem_ready delayed 2 cycles → states 0,1,2,3,3,3,4,0; mem_read high for 3 cycles; reg_write=10 and mem_to_reg=01 in WB only.
- Opcode 3, zero waits → branch=01 for exactly one EXEC cycle; back in FETCH on cycle 3; reg_write=0 throughout.
- Opcode 9 → branch=11 in EXEC; WB has reg_write=01, mem_to_reg=10.
- Opcode 12 → illegal_op 1-cycle pulse in DECODE; next state FETCH; no write strobe.
- WAIT_MAX=3, imem_ready held 0 → bus_err pulses on the 4th FETCH cycle. Separate run: ready arriving on that same cycle → DECODE, no bus_err.
- rst_n low during MEM of opcode 6 → mem_write drops asynchronously and state=0. With MCTRL_HALT_EN, opcode 63 → halted=1 and imem_req=0 until reset.
